// File: rtl/punc_mc_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : punc_mc_control_if
//  Purpose  : Memory request/acknowledge bundle between the PUnC multicycle
//             controller and a variable-latency memory port.
//  Signals  : mem_req     request pending (held until mem_ack)
//             mem_we      request is a write (valid with mem_req)
//             mem_addr_s  address mux select 0=PC 1=EA 2=MDR
//             mem_ack     memory completes the pending request this cycle
//  Modports : master (controller side), slave (memory side)
//  Revision : 1.0  initial release
// ============================================================================
interface punc_mc_control_if;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_addr_s;
    logic       mem_ack;

    modport master (output mem_req, output mem_we, output mem_addr_s, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_addr_s, output mem_ack);
endinterface
`default_nettype wire

// File: rtl/punc_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : punc_mc_control
//  Purpose  : Multicycle control unit for the PUnC LC-3 core. Sequences
//             fetch/decode/execute/memory phases, talks to memory over a
//             req/ack handshake, guards each wait with an ack watchdog and
//             parks in HALT on TRAP or watchdog expiry.
//  Ports    : clk, rst (async, active high)
//             ir, n, z, p           datapath instruction and flags
//             mem (if master)       mem_req / mem_we / mem_addr_s / mem_ack
//             write_ir, inc_pc, pc_ld, pc_s, write_rf, rf_s, write_status,
//             alu_s, op2_s          datapath strobes
//             halted, fault         status
//             cycle_cnt, retired_cnt  perf counters (PUNC_PERF_CNT_EN only)
//  Config   : `define PUNC_PERF_CNT_EN adds the performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module punc_mc_control #(
    parameter int WORD_W      = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [WORD_W-1:0] ir,
    input  wire logic              n,
    input  wire logic              z,
    input  wire logic              p,
    punc_mc_control_if.master      mem,
    output logic                   write_ir,
    output logic                   inc_pc,
    output logic                   pc_ld,
    output logic [1:0]             pc_s,
    output logic                   write_rf,
    output logic [1:0]             rf_s,
    output logic                   write_status,
    output logic [2:0]             alu_s,
    output logic                   op2_s,
    output logic                   halted,
    output logic                   fault
`ifdef PUNC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       retired_cnt
`endif
);

    localparam logic [3:0] c_FETCH   = 4'd0;
    localparam logic [3:0] c_FETCH_W = 4'd1;
    localparam logic [3:0] c_DECODE  = 4'd2;
    localparam logic [3:0] c_EXEC    = 4'd3;
    localparam logic [3:0] c_MEM     = 4'd4;
    localparam logic [3:0] c_MEM_W   = 4'd5;
    localparam logic [3:0] c_IND     = 4'd6;
    localparam logic [3:0] c_IND_W   = 4'd7;
    localparam logic [3:0] c_HALT    = 4'd8;

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_JSR = 4'b0100;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_LDI = 4'b1010;
    localparam logic [3:0] c_OP_STI = 4'b1011;
    localparam logic [3:0] c_OP_JMP = 4'b1100;
    localparam logic [3:0] c_OP_LEA = 4'b1110;
    localparam logic [3:0] c_OP_TRP = 4'b1111;

    localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Count value seen during the last waiting cycle before expiry.
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [1:0]      r_mem_addr_s;
    logic            r_ind;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_fault;

    logic [3:0] w_op;
    logic       w_in_wait;
    logic       w_ack;
    logic       w_expire;
    logic       w_is_store;
    logic       w_unused;

    assign w_op       = ir[WORD_W-1 -: 4];
    assign w_unused   = ^ir;
    assign w_in_wait  = (r_state == c_FETCH_W) || (r_state == c_MEM_W) || (r_state == c_IND_W);
    // Acks are only meaningful while a request is outstanding.
    assign w_ack      = w_in_wait && mem.mem_ack;
    // An ack arriving in the final allowed cycle beats the watchdog.
    assign w_expire   = (TIMEOUT_CYC != 0) && w_in_wait && !mem.mem_ack && (r_wd_cnt == c_WD_LAST);
    assign w_is_store = (w_op == c_OP_ST) || (w_op == c_OP_STR) || (w_op == c_OP_STI);

    assign mem.mem_req    = r_mem_req;
    assign mem.mem_we     = r_mem_we;
    assign mem.mem_addr_s = r_mem_addr_s;
    assign fault          = r_fault;

    // State and request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_FETCH;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr_s <= 2'd0;
            r_ind        <= 1'b0;
            r_wd_cnt     <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_expire)
                r_fault <= 1'b1;

            // Request fields are loaded on the way into a *_W state and held
            // there untouched until the ack (or watchdog) edge.
            if (r_state == c_FETCH) begin
                r_mem_req    <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr_s <= 2'd0;
            end else if (r_state == c_IND) begin
                r_mem_req    <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr_s <= 2'd1;
            end else if (r_state == c_MEM) begin
                r_mem_req    <= 1'b1;
                r_mem_we     <= w_is_store;
                r_mem_addr_s <= r_ind ? 2'd2 : 2'd1;
            end else if (w_ack || w_expire) begin
                r_mem_req    <= 1'b0;
                r_mem_we     <= 1'b0;
                r_mem_addr_s <= 2'd0;
            end

            // Remembers that the data access must use the fetched pointer.
            if (r_state == c_FETCH)
                r_ind <= 1'b0;
            else if ((r_state == c_IND_W) && w_ack)
                r_ind <= 1'b1;

            // Every *_W state is entered from a non-wait state, so holding the
            // count at zero outside waits clears it on entry.
            if (!w_in_wait)
                r_wd_cnt <= '0;
            else if (!mem.mem_ack && (r_wd_cnt != c_WD_LAST))
                r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:   w_next = c_FETCH_W;
            c_FETCH_W: if (w_ack) w_next = c_DECODE;
            c_DECODE:  w_next = (w_op == c_OP_TRP) ? c_HALT : c_EXEC;
            c_EXEC: begin
                case (w_op)
                    c_OP_LD, c_OP_LDR, c_OP_ST, c_OP_STR: w_next = c_MEM;
                    c_OP_LDI, c_OP_STI:                   w_next = c_IND;
                    default:                              w_next = c_FETCH;
                endcase
            end
            c_IND:     w_next = c_IND_W;
            c_IND_W:   if (w_ack) w_next = c_MEM;
            c_MEM:     w_next = c_MEM_W;
            c_MEM_W:   if (w_ack) w_next = c_FETCH;
            c_HALT:    w_next = c_HALT;
            default:   w_next = c_FETCH;
        endcase
        if (w_expire)
            w_next = c_HALT;
    end

    // Datapath strobes
    always_comb begin
        write_ir     = 1'b0;
        inc_pc       = 1'b0;
        pc_ld        = 1'b0;
        pc_s         = 2'd0;
        write_rf     = 1'b0;
        rf_s         = 2'd0;
        write_status = 1'b0;
        alu_s        = 3'd0;
        op2_s        = 1'b0;
        halted       = (r_state == c_HALT);
        case (r_state)
            c_FETCH_W: begin
                write_ir = w_ack;
                inc_pc   = w_ack;
            end
            c_EXEC: begin
                case (w_op)
                    c_OP_ADD, c_OP_AND, c_OP_NOT: begin
                        write_rf     = 1'b1;
                        write_status = 1'b1;
                        op2_s        = ir[5];
                        alu_s        = (w_op == c_OP_ADD) ? 3'd0 :
                                       (w_op == c_OP_AND) ? 3'd1 : 3'd2;
                    end
                    c_OP_BR: begin
                        pc_ld = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
                    end
                    c_OP_JMP: begin
                        pc_ld = 1'b1;
                        pc_s  = 2'd2;
                    end
                    c_OP_JSR: begin
                        // Link captures the already-incremented PC before pc_ld lands.
                        write_rf = 1'b1;
                        rf_s     = 2'd2;
                        pc_ld    = 1'b1;
                        pc_s     = ir[11] ? 2'd1 : 2'd2;
                    end
                    c_OP_LEA: begin
                        write_rf     = 1'b1;
                        rf_s         = 2'd3;
                        write_status = 1'b1;
                        alu_s        = 3'd4;
                    end
                    default: ;
                endcase
            end
            c_IND, c_IND_W, c_MEM: alu_s = 3'd4;
            c_MEM_W: begin
                alu_s = 3'd4;
                if (w_ack && !w_is_store) begin
                    write_rf     = 1'b1;
                    rf_s         = 2'd1;
                    write_status = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef PUNC_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retired_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else if (r_state != c_HALT) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_next == c_FETCH)
                r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign retired_cnt = r_retired_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_punc_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_punc_mc_control
//  Purpose  : Directed self-checking bench for punc_mc_control
//             (TIMEOUT_CYC = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_punc_mc_control;

    localparam int c_TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ack = 1'b0;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;
    logic [15:0] ir = 16'h0000;

    logic       write_ir, inc_pc, pc_ld, write_rf, write_status, op2_s, halted, fault;
    logic [1:0] pc_s, rf_s;
    logic [2:0] alu_s;
`ifdef PUNC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    punc_mc_control_if mif();
    assign mif.mem_ack = ack;

    wire       mem_req    = mif.mem_req;
    wire       mem_we     = mif.mem_we;
    wire [1:0] mem_addr_s = mif.mem_addr_s;

    punc_mc_control #(.WORD_W(16), .TIMEOUT_CYC(c_TO), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir),
        .n            (n),
        .z            (z),
        .p            (p),
        .mem          (mif.master),
        .write_ir     (write_ir),
        .inc_pc       (inc_pc),
        .pc_ld        (pc_ld),
        .pc_s         (pc_s),
        .write_rf     (write_rf),
        .rf_s         (rf_s),
        .write_status (write_status),
        .alu_s        (alu_s),
        .op2_s        (op2_s),
        .halted       (halted),
        .fault        (fault)
`ifdef PUNC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .retired_cnt  (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Starts mid-cycle in FETCH, ends mid-cycle in DECODE (1-cycle ack).
    task automatic do_fetch(input logic [15:0] instr);
        nxt();
        chk("fetch_req",  {31'd0, mem_req}, 1);
        chk("fetch_addr", {30'd0, mem_addr_s}, 0);
        ir  = instr;
        ack = 1'b1;
        #1;
        chk("fetch_wir_inc", {30'd0, write_ir, inc_pc}, 3);
        nxt();
        ack = 1'b0;
    endtask

    // Starts mid-cycle in a *_W state; raises ack in its lat-th cycle.
    task automatic wait_ack(input int lat);
        for (int i = 1; i < lat; i++) begin
            nxt();
            chk("wait_req_held", {31'd0, mem_req}, 1);
        end
        ack = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        nxt(); nxt();
        chk("rst_req",    {31'd0, mem_req}, 0);
        chk("rst_we_addr", {29'd0, mem_we, mem_addr_s}, 0);
        chk("rst_status", {30'd0, halted, fault}, 0);
        chk("rst_strobes", {27'd0, write_rf, write_ir, inc_pc, pc_ld, write_status}, 0);
        rst = 1'b0;

        // ADD R1,R1,#3
        do_fetch(16'h1263);
        chk("dec_quiet", {31'd0, write_rf}, 0);
        nxt();
        chk("add_wrf_ws", {30'd0, write_rf, write_status}, 3);
        chk("add_alu",    {29'd0, alu_s}, 0);
        chk("add_op2",    {31'd0, op2_s}, 1);
        chk("add_rfs",    {30'd0, rf_s}, 0);
        nxt();
        chk("add_back_fetch", {31'd0, write_rf}, 0);

        // BRz taken then not taken
        z = 1'b1;
        do_fetch(16'h0405);
        nxt();
        chk("brz_taken", {29'd0, pc_ld, pc_s}, 3'b100);
        nxt();
        z = 1'b0; n = 1'b1;
        do_fetch(16'h0405);
        nxt();
        chk("brz_not_taken", {31'd0, pc_ld}, 0);
        nxt();
        n = 1'b0;

        // JSR with PC-relative target
        do_fetch(16'h4800);
        nxt();
        chk("jsr_link", {29'd0, write_rf, rf_s}, 3'b110);
        chk("jsr_pc",   {29'd0, pc_ld, pc_s}, 3'b101);
        chk("jsr_no_ws", {31'd0, write_status}, 0);
        nxt();

        // AND register form
        do_fetch(16'h5042);
        nxt();
        chk("and_alu_op2", {28'd0, alu_s, op2_s}, 4'b0010);
        chk("and_wrf", {31'd0, write_rf}, 1);
        nxt();

        // Reserved opcode behaves as NOP
        do_fetch(16'hD000);
        nxt();
        chk("nop_strobes", {29'd0, write_rf, pc_ld, write_status}, 0);
        nxt();
        chk("nop_no_req", {31'd0, mem_req}, 0);

        // LDI with 5-cycle memory
        do_fetch(16'hA002);
        nxt();
        chk("ldi_exec_quiet", {30'd0, write_rf, mem_req}, 0);
        nxt();
        nxt();
        chk("ind_req", {28'd0, mem_req, mem_we, mem_addr_s}, 4'b1001);
        wait_ack(5);
        chk("ind_ack_no_wrf", {31'd0, write_rf}, 0);
        nxt();
        ack = 1'b1;  // stray ack in MEM must be ignored
        #1;
        chk("mem_req_idle", {31'd0, mem_req}, 0);
        nxt();
        ack = 1'b0;
        chk("ldi_mem_req", {28'd0, mem_req, mem_we, mem_addr_s}, 4'b1010);
        wait_ack(5);
        chk("ldi_load_wb", {28'd0, write_rf, rf_s, write_status}, 4'b1011);
        nxt();
        ack = 1'b0;
        chk("ldi_done", {30'd0, write_rf, mem_req}, 0);

        // ST with ack in the last allowed cycle: ack wins over watchdog
        do_fetch(16'h3001);
        nxt(); nxt(); nxt();
        chk("st_req", {28'd0, mem_req, mem_we, mem_addr_s}, 4'b1101);
        wait_ack(c_TO);
        chk("st_no_wrf", {31'd0, write_rf}, 0);
        nxt();
        ack = 1'b0;
        chk("ack_wins", {29'd0, halted, fault, mem_req}, 0);

        // Reset in MEM_W of STR aborts the request asynchronously
        do_fetch(16'h7081);
        nxt(); nxt(); nxt();
        chk("str_req_we", {30'd0, mem_req, mem_we}, 3);
        rst = 1'b1;
        #1;
        chk("rst_abort", {30'd0, mem_req, mem_we}, 0);
        nxt();
        rst = 1'b0;
        do_fetch(16'h1263);
        nxt();
        chk("post_rst_add", {31'd0, write_rf}, 1);
        nxt();

        // ST with no ack: watchdog expiry
        do_fetch(16'h3001);
        nxt(); nxt(); nxt();
        for (int i = 2; i <= c_TO; i++) begin
            nxt();
            chk("wd_waiting", {30'd0, mem_req, fault}, 2);
        end
        nxt();
        chk("wd_expired", {29'd0, fault, halted, mem_req}, 3'b110);
        ack = 1'b1;
        nxt(); nxt();
        chk("halt_absorb", {29'd0, fault, halted, mem_req}, 3'b110);
        ack = 1'b0;

        // TRAP after reset
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk("rst_clears_fault", {30'd0, fault, halted}, 0);
        do_fetch(16'hF025);
        nxt();
        chk("trap_halt", {30'd0, halted, mem_req}, 2);
        repeat (3) nxt();
        chk("trap_stay", {29'd0, halted, write_rf, fault}, 3'b100);
`ifdef PUNC_PERF_CNT_EN
        chk("perf_cycles",  cycle_cnt, 3);
        chk("perf_retired", retired_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
